// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO and runs multi-cycle
// mult/multu/div/divu/madd operations plus single-cycle mthi/mtlo writes.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MDOp,
    input  logic        HILOSel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HILOOut
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_MADD  = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_thi;
    logic [31:0]        r_tlo;

    logic               w_is_md;
    logic [63:0]        w_res;
    logic [CNT_W-1:0]   w_lat;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;

    // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly
    // instead of hitting the language's signed-overflow corner.
    function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ua, ub, q, r;
        ua = a[31] ? (~a + 32'd1) : a;
        ub = b[31] ? (~b + 32'd1) : b;
        q  = ua / ub;
        r  = ua % ub;
        if (a[31] ^ b[31]) q = ~q + 32'd1;
        if (a[31])         r = ~r + 32'd1;
        return {r, q};
    endfunction

    function automatic logic [63:0] udiv(input logic [31:0] a, input logic [31:0] b);
        return {a % b, a / b};
    endfunction

    assign w_is_md  = (MDOp == OP_MULT) || (MDOp == OP_MULTU) || (MDOp == OP_DIV) ||
                      (MDOp == OP_DIVU) || (MDOp == OP_MADD);
    assign Start    = w_is_md && !Req && !r_busy;
    assign Busy     = r_busy;
    assign HILOOut  = HILOSel ? r_lo : r_hi;
    assign w_prod_s = $signed(A) * $signed(B);
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    always_comb begin
        w_res = {r_hi, r_lo};
        w_lat = CNT_W'(MULT_CYCLES);
        case (MDOp)
            OP_MULT:  w_res = w_prod_s;
            OP_MULTU: w_res = w_prod_u;
            OP_MADD:  w_res = {r_hi, r_lo} + w_prod_s;
            OP_DIV: begin
                w_lat = CNT_W'(DIV_CYCLES);
                if (B != 32'd0) w_res = sdiv(A, B);
            end
            OP_DIVU: begin
                w_lat = CNT_W'(DIV_CYCLES);
                if (B != 32'd0) w_res = udiv(A, B);
            end
            default: ;
        endcase
    end

    // Result is captured at the start edge; HI/LO cannot change during RUN,
    // so divide-by-zero simply re-commits the current HI/LO.
    always_ff @(posedge clk) begin
        if (Start) begin
            r_thi <= w_res[63:32];
            r_tlo <= w_res[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_state <= RUN;
                        r_cnt   <= w_lat;
                        r_busy  <= 1'b1;
                    end else if (!Req && MDOp == OP_MTHI) begin
                        r_hi <= A;
                    end else if (!Req && MDOp == OP_MTLO) begin
                        r_lo <= A;
                    end
                end
                RUN: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_hi    <= r_thi;
                        r_lo    <= r_tlo;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, arithmetic, HI/LO moves, flush,
// reset abort and back-to-back issue with hand-computed expectations.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  MDOp;
    logic        HILOSel;
    logic [31:0] A;
    logic [31:0] B;
    logic        Req;
    logic        Start;
    logic        Busy;
    logic [31:0] HILOOut;

    int checks = 0;
    int errors = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .MDOp(MDOp), .HILOSel(HILOSel),
        .A(A), .B(B), .Req(Req), .Start(Start), .Busy(Busy), .HILOOut(HILOOut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        HILOSel = 1'b0; #1; hi = HILOOut;
        HILOSel = 1'b1; #1; lo = HILOOut;
    endtask

    // Counts cycles with Busy=1, bounded so a stuck Busy cannot hang the run.
    task automatic wait_busy(output int n);
        n = 0;
        while (Busy && n < 50) begin
            n++;
            tick();
        end
    endtask

    // Drives an op for one edge, then returns to MDOp=none.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        MDOp = op; A = a; B = b;
        tick();
        MDOp = 3'b000;
    endtask

    task automatic test_reset();
        logic [31:0] hi, lo;
        reset = 1'b1; MDOp = 3'b000; HILOSel = 1'b0; A = '0; B = '0; Req = 1'b0;
        tick(); tick();
        reset = 1'b0;
        read_hilo(hi, lo);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        checks++; if (Start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", Start); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    endtask

    task automatic test_mult();
        logic [31:0] hi, lo;
        int n;
        MDOp = 3'b001; A = 32'hFFFFFFFD; B = 32'd5; #1;
        checks++; if (Start !== 1'b1) begin errors++; $display("FAIL mult_start: got %b expected 1", Start); end
        tick();
        MDOp = 3'b000;
        read_hilo(hi, lo);
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL mult_inflight_lo: got %h expected 0", lo); end
        wait_busy(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 5", n); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo: got %h expected fffffff1", lo); end
    endtask

    task automatic test_div();
        logic [31:0] hi, lo;
        int n;
        issue(3'b100, 32'd7, 32'd2);
        wait_busy(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL divu_busy_cycles: got %0d expected 10", n); end
        read_hilo(hi, lo);
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo: got %h expected 3", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h expected 1", hi); end
        issue(3'b011, 32'hFFFFFFF9, 32'd2);
        wait_busy(n);
        read_hilo(hi, lo);
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
    endtask

    task automatic test_madd();
        logic [31:0] hi, lo;
        int n;
        MDOp = 3'b101; A = 32'd1; #1;
        checks++; if (Start !== 1'b0) begin errors++; $display("FAIL mthi_start: got %b expected 0", Start); end
        tick();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", Busy); end
        issue(3'b110, 32'd2, 32'd0);
        read_hilo(hi, lo);
        checks++; if (hi !== 32'd1 || lo !== 32'd2) begin errors++; $display("FAIL mthi_mtlo: got %h_%h expected 00000001_00000002", hi, lo); end
        issue(3'b111, 32'd3, 32'd4);
        wait_busy(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL madd_busy_cycles: got %0d expected 5", n); end
        read_hilo(hi, lo);
        checks++; if (lo !== 32'h0000000E) begin errors++; $display("FAIL madd_lo: got %h expected 0000000e", lo); end
        HILOSel = 1'b0; #1;
        checks++; if (HILOOut !== 32'd1) begin errors++; $display("FAIL madd_hi_sel0: got %h expected 1", HILOOut); end
    endtask

    task automatic test_div_zero();
        logic [31:0] hi, lo;
        int n;
        issue(3'b110, 32'h55, 32'd0);
        issue(3'b011, 32'd9, 32'd0);
        wait_busy(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL divzero_busy_cycles: got %0d expected 10", n); end
        read_hilo(hi, lo);
        checks++; if (lo !== 32'h55) begin errors++; $display("FAIL divzero_lo: got %h expected 55", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divzero_hi: got %h expected 1", hi); end
        issue(3'b011, 32'h80000000, 32'hFFFFFFFF);
        wait_busy(n);
        read_hilo(hi, lo);
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL divovf_lo: got %h expected 80000000", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL divovf_hi: got %h expected 0", hi); end
    endtask

    task automatic test_req();
        logic [31:0] hi, lo;
        int n;
        Req = 1'b1; MDOp = 3'b001; A = 32'd2; B = 32'd3; #1;
        checks++; if (Start !== 1'b0) begin errors++; $display("FAIL req_start: got %b expected 0", Start); end
        tick();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL req_busy: got %b expected 0", Busy); end
        MDOp = 3'b101; A = 32'hDEAD;
        tick();
        MDOp = 3'b000; Req = 1'b0;
        read_hilo(hi, lo);
        checks++; if (hi !== 32'd0 || lo !== 32'h80000000) begin errors++; $display("FAIL req_hilo: got %h_%h expected 00000000_80000000", hi, lo); end
        issue(3'b001, 32'd2, 32'd3);
        Req = 1'b1;
        tick();
        wait_busy(n);
        Req = 1'b0;
        checks++; if (n !== 4) begin errors++; $display("FAIL req_run_busy: got %0d expected 4 remaining", n); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'd0 || lo !== 32'd6) begin errors++; $display("FAIL req_run_commit: got %h_%h expected 00000000_00000006", hi, lo); end
    endtask

    task automatic test_ignore();
        logic [31:0] hi, lo;
        int n;
        issue(3'b010, 32'hFFFFFFFF, 32'd2);
        MDOp = 3'b110; A = 32'h1234; #1;
        checks++; if (Start !== 1'b0) begin errors++; $display("FAIL busy_start: got %b expected 0", Start); end
        tick();
        MDOp = 3'b011; A = 32'd100; B = 32'd7;
        tick();
        MDOp = 3'b000;
        wait_busy(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL busy_remaining: got %0d expected 3", n); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'd1 || lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_ignore: got %h_%h expected 00000001_fffffffe", hi, lo); end
        tick(); tick();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL no_queue: got %b expected 0", Busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] hi, lo;
        int n;
        issue(3'b001, 32'd2, 32'd3);
        wait_busy(n);
        HILOSel = 1'b1;
        MDOp = 3'b010; A = 32'd4; B = 32'd5; #1;
        checks++; if (Start !== 1'b1 || HILOOut !== 32'd6) begin errors++; $display("FAIL b2b_restart: got start=%b lo=%h expected start=1 lo=00000006", Start, HILOOut); end
        tick();
        MDOp = 3'b000;
        wait_busy(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected 5", n); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'd0 || lo !== 32'd20) begin errors++; $display("FAIL b2b_result: got %h_%h expected 00000000_00000014", hi, lo); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] hi, lo;
        issue(3'b001, 32'd7, 32'd7);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        read_hilo(hi, lo);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", Busy); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rstmid_hilo: got %h_%h expected 0_0", hi, lo); end
        repeat (8) tick();
        read_hilo(hi, lo);
        checks++; if (Busy !== 1'b0 || lo !== 32'd0) begin errors++; $display("FAIL rstmid_late: got busy=%b lo=%h expected busy=0 lo=0", Busy, lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_madd();
        test_div_zero();
        test_req();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
